// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its queue controller.
package instr_register_pkg;

    typedef enum logic [3:0] {
        ZERO,
        PASSA,
        PASSB,
        ADD,
        SUB,
        MULT,
        DIV,
        MOD
    } opcode_t;

    typedef logic signed [31:0] operand_t;
    typedef logic [4:0]         address_t;

    typedef struct packed {
        opcode_t            opc;
        operand_t           op_a;
        operand_t           op_b;
        logic signed [63:0] rezultat;
    } instruction_t;

    localparam int IR_DEPTH = 32;

    typedef logic [5:0] count_t;

    // Circular-buffer pointer advance; wraps explicitly so non-power-of-two-sized
    // address types still roll over at the queue depth.
    function automatic address_t ptr_inc(address_t p, int depth);
        return (int'(p) == depth - 1) ? '0 : p + 1'b1;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: on a tie the requester that did not win last time wins.
module rr_arbiter2 (
    input  logic [1:0] i_valid,
    input  logic       i_block,
    input  logic       i_last_grant,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = 2'b00;
        if (!i_block) begin
            if (i_valid[0] && (!i_valid[1] || i_last_grant)) begin
                o_grant[0] = 1'b1;
            end else if (i_valid[1]) begin
                o_grant[1] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/instr_register_ctrl.sv
// Circular-queue controller for instr_register: arbitrates two producers into
// write slots and sequences read_pointer for a single consumer.
module instr_register_ctrl
    import instr_register_pkg::*;
#(
    parameter int DEPTH       = IR_DEPTH,
    parameter int RST_STRETCH = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  opcode_t                req0_opc,
    input  operand_t               req0_op_a,
    input  operand_t               req0_op_b,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  opcode_t                req1_opc,
    input  operand_t               req1_op_a,
    input  operand_t               req1_op_b,
    input  logic                   rd_req,
    output logic                   rd_ready,
    output logic                   rd_valid,
    output instruction_t           rd_data,
    output logic                   load_en,
    output logic                   ir_reset_n,
    output opcode_t                opcode,
    output operand_t               operand_a,
    output operand_t               operand_b,
    output address_t               write_pointer,
    output address_t               read_pointer,
    input  instruction_t           instruction_word,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = (RST_STRETCH < 2) ? 1 : $clog2(RST_STRETCH + 1);

    logic [1:0]    w_grant;
    logic          w_wr;
    logic          w_rd;
    opcode_t       w_opc;
    operand_t      w_op_a;
    operand_t      w_op_b;

    logic          r_last_grant;
    address_t      r_wr_ptr;
    address_t      r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_load_en;
    address_t      r_write_pointer;
    opcode_t       r_opcode;
    operand_t      r_op_a;
    operand_t      r_op_b;
    address_t      r_read_pointer;
    logic          r_rd_pend;
    logic          r_rd_valid;
    instruction_t  r_rd_data;
    logic [SW-1:0] r_rst_cnt;
    logic          r_ir_rst_n;

    rr_arbiter2 u_arb (
        .i_valid      ({req1_valid, req0_valid}),
        .i_block      (full),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant)
    );

    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == '0);

    // Every grant is a completed handshake since ready implies valid.
    assign w_wr   = |w_grant;
    assign w_rd   = rd_req & ~empty;
    assign w_opc  = w_grant[1] ? req1_opc  : req0_opc;
    assign w_op_a = w_grant[1] ? req1_op_a : req0_op_a;
    assign w_op_b = w_grant[1] ? req1_op_b : req0_op_b;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant    <= 1'b1;
            r_wr_ptr        <= '0;
            r_load_en       <= 1'b0;
            r_write_pointer <= '0;
            r_opcode        <= ZERO;
            r_op_a          <= '0;
            r_op_b          <= '0;
        end else begin
            r_load_en <= w_wr;
            if (w_wr) begin
                r_write_pointer <= r_wr_ptr;
                r_opcode        <= w_opc;
                r_op_a          <= w_op_a;
                r_op_b          <= w_op_b;
                r_wr_ptr        <= ptr_inc(r_wr_ptr, DEPTH);
                r_last_grant    <= w_grant[1];
            end
        end
    end

    // instruction_word is combinational on read_pointer, so data is taken one edge after the pointer moves.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr       <= '0;
            r_read_pointer <= '0;
            r_rd_pend      <= 1'b0;
            r_rd_valid     <= 1'b0;
            r_rd_data      <= '0;
        end else begin
            r_rd_pend  <= w_rd;
            r_rd_valid <= r_rd_pend;
            if (w_rd) begin
                r_read_pointer <= r_rd_ptr;
                r_rd_ptr       <= ptr_inc(r_rd_ptr, DEPTH);
            end
            if (r_rd_pend) begin
                r_rd_data <= instruction_word;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rst_cnt  <= SW'(RST_STRETCH);
            r_ir_rst_n <= 1'b0;
        end else begin
            if (r_rst_cnt != '0) begin
                r_rst_cnt <= r_rst_cnt - 1'b1;
            end
            r_ir_rst_n <= (r_rst_cnt <= SW'(1));
        end
    end

    assign req0_ready    = w_grant[0];
    assign req1_ready    = w_grant[1];
    assign rd_ready      = ~empty;
    assign rd_valid      = r_rd_valid;
    assign rd_data       = r_rd_data;
    assign load_en       = r_load_en;
    assign ir_reset_n    = r_ir_rst_n;
    assign opcode        = r_opcode;
    assign operand_a     = r_op_a;
    assign operand_b     = r_op_b;
    assign write_pointer = r_write_pointer;
    assign read_pointer  = r_read_pointer;
    assign count         = r_count;

endmodule

// File: doc/instr_register_ctrl.md
Name: instr_register_ctrl

Overview:
- Controller that shares the 32-entry instr_register between two instruction producers (req0, req1) and one result consumer.
- Runs the register as a circular queue. Grants one producer per cycle, round-robin, and drives load_en, write_pointer, opcode and operands.
- Sequences read_pointer for the consumer and returns the stored instruction_word, including the computed rezultat.
- Sits between the stimulus/traffic sources and instr_register. It replaces direct pointer driving by the bench.

Parameters:
- DEPTH, 32, number of register entries; power of two; pointer width = $clog2(DEPTH).
- RST_STRETCH, 1, clk cycles that ir_reset_n stays low after reset deasserts.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  producer 0 holds an instruction.
- req0_ready  out  1  producer 0 granted this cycle.
- req0_opc  in  opcode_t  producer 0 opcode.
- req0_op_a  in  operand_t  producer 0 operand a.
- req0_op_b  in  operand_t  producer 0 operand b.
- req1_valid, req1_ready, req1_opc, req1_op_a, req1_op_b: same as req0, for producer 1.
- rd_req  in  1  consumer requests oldest entry.
- rd_ready  out  1  queue not empty (!empty).
- rd_valid  out  1  one-cycle pulse; rd_data valid.
- rd_data  out  instruction_t  entry read back (opc, op_a, op_b, rezultat).
- load_en  out  1  to instr_register.
- ir_reset_n  out  1  to instr_register reset_n.
- opcode  out  opcode_t  to instr_register.
- operand_a  out  operand_t  to instr_register.
- operand_b  out  operand_t  to instr_register.
- write_pointer  out  address_t  to instr_register.
- read_pointer  out  address_t  to instr_register.
- instruction_word  in  instruction_t  from instr_register (combinational on read_pointer).
- count  out  $clog2(DEPTH)+1  occupied entries, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Reset (async assert):
  - wr_ptr, rd_ptr, count = 0.
  - load_en, rd_valid = 0.
  - write_pointer, read_pointer, operand_a, operand_b = 0; opcode = ZERO; rd_data = '0.
  - last_grant = 1, so req0 wins the first contention.
  - ir_reset_n = 0; it goes high RST_STRETCH posedges after reset falls.
- Reset mid-operation: any in-flight write or read is dropped, no rd_valid is emitted, and the queue is empty afterwards.
- Arbitration, per cycle:
  - If full, no grant; req0_ready = req1_ready = 0.
  - Only one producer valid: that producer is granted.
  - Both valid: grant the one not equal to last_grant.
  - reqN_ready is combinational from reqN_valid, full and last_grant. It never asserts without the matching valid.
  - Handshake completes when reqN_valid & reqN_ready are both high at a posedge.
- Write issue:
  - On the handshake edge T, register: load_en = 1, write_pointer = wr_ptr, opcode/operand_a/operand_b = the granted request.
  - Also at T: wr_ptr++ (wraps DEPTH-1 -> 0), last_grant = granted id.
  - instr_register captures the entry at edge T+1.
  - With no grant, load_en = 0 the next cycle; the operand registers hold their values.
- Read:
  - At edge R, if rd_req & !empty: read_pointer = rd_ptr, rd_ptr++ (wraps).
  - At edge R+1: rd_data = instruction_word, rd_valid = 1 for exactly one cycle.
  - rd_req while empty is ignored. It is not queued, even if a write is granted in the same cycle.
- Count:
  - +1 on write handshake, -1 on accepted read; unchanged when both happen in the same cycle.
  - A write while full is never granted. A read while full is allowed.
- Read-after-write: the earliest a just-granted entry can be read is edge T+1, with rd_valid at T+2. The data is already stored at T+1, so no bypass is needed.
- Back-to-back operation: one write and one read per cycle are sustainable indefinitely.
- Arithmetic: none on operands; the controller passes opcode and operands through unchanged.

Decomposition:
- instr_register_pkg (existing):
  - opcode_t, operand_t, address_t, instruction_t are used unchanged.
  - Add IR_DEPTH = 32 and typedef count_t = logic [5:0].
- Sub-module rr_arbiter2:
  - Inputs: valid[1:0], block (full), last_grant.
  - Outputs: one-hot grant[1:0].
  - Purely combinational; last_grant is held in the controller.

Test Plan:
- Reset, then req0 writes {ADD, 5, 3}:
  - load_en = 1 and write_pointer = 0 one cycle after the handshake.
  - rd_req then gives rd_valid two cycles later with opc = ADD, op_a = 5, op_b = 3, rezultat = 8.
- Both producers valid continuously for 6 cycles:
  - Grants alternate 0,1,0,1,0,1.
  - write_pointer runs 0..5; count = 6.
- Fill 32 entries:
  - full = 1 and both ready = 0 while req0_valid = 1.
  - One read drops count to 31; the next write goes to slot 0 (wrap).
- rd_req with empty = 1 and a write granted in the same cycle:
  - No rd_valid the next cycle.
  - A second rd_req one cycle later returns the entry with rd_valid.
- Simultaneous write and read at count = 4:
  - count stays 4; wr_ptr and rd_ptr both advance.
- Assert reset while 3 entries are queued and a read is in flight:
  - No rd_valid is emitted; count = 0; load_en = 0.
  - ir_reset_n is low and returns high 1 cycle after reset falls.
